// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle host: FSM state encoding,
// default geometry/FIFO/timeout sizes and the pixel-count helper.
package tri_pkg;

  localparam int COORD_W    = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 16;
  localparam int PIX_CNT_W  = 7;

  localparam logic [PIX_CNT_W-1:0] PIX_CNT_MAX = 7'd127;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND1   = 3'd1,
    SEND2   = 3'd2,
    SEND3   = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } tri_state_e;

  // Saturating increment of the per-triangle pixel count.
  function automatic logic [PIX_CNT_W-1:0] pix_cnt_inc(
    input logic [PIX_CNT_W-1:0] cnt,
    input logic                 en
  );
    if (en && (cnt != PIX_CNT_MAX)) begin
      return cnt + 7'd1;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/tri_pix_fifo.sv
// Pixel FIFO between the raster engine and the downstream consumer.
// Uses an occupancy counter so depths that are not a power of two still
// wrap correctly. A push into a full FIFO is accepted only when the head
// is popped in the same cycle; otherwise it is dropped and flagged.
module tri_pix_fifo #(
  parameter int DW    = 6,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop_ready,
  output logic          head_valid,
  output logic [DW-1:0] head_data,
  output logic          drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake decode: pop only a valid head; push if room or head leaves.
  always_comb begin
    head_valid = (count != {CNT_W{1'b0}});
    full       = (count == CNT_FULL);
    pop        = head_valid & pop_ready;
    push_ok    = push & (~full | pop);
    drop       = push & full & ~pop;
    head_data  = mem[rd_ptr];
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tri_host.sv
// Triangle host: gathers three vertices, streams them to the raster
// engine (nt strobe on the first), waits for the engine's busy pulse with
// a timeout, counts rendered pixels and buffers them in a pixel FIFO.
module tri_host #(
  parameter int COORD_W    = tri_pkg::COORD_W,
  parameter int FIFO_DEPTH = tri_pkg::FIFO_DEPTH,
  parameter int TIMEOUT    = tri_pkg::TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vin_valid,
  output logic               vin_ready,
  input  logic [COORD_W-1:0] vin_x,
  input  logic [COORD_W-1:0] vin_y,
  output logic               nt,
  output logic [COORD_W-1:0] xi,
  output logic [COORD_W-1:0] yi,
  input  logic               busy,
  input  logic               po,
  input  logic [COORD_W-1:0] xo,
  input  logic [COORD_W-1:0] yo,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               tri_done,
  output logic [6:0]         tri_pixels,
  input  logic               clr_err,
  output logic               err_ovf,
  output logic               err_tmo
);

  import tri_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  tri_state_e             state;
  tri_state_e             next_state;
  logic [1:0]             gcnt;
  logic [COORD_W-1:0]     vx [3];
  logic [COORD_W-1:0]     vy [3];
  logic [TMO_W-1:0]       tmo_cnt;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic                   tmo_fire;
  logic                   tri_load;
  logic                   vin_hs;
  logic                   fifo_drop;
  logic [2*COORD_W-1:0]   head_data;

  // Next-state and Moore/Mealy output decode.
  always_comb begin
    next_state = state;
    vin_ready  = 1'b0;
    nt         = 1'b0;
    xi         = {COORD_W{1'b0}};
    yi         = {COORD_W{1'b0}};
    tri_done   = 1'b0;
    tmo_fire   = 1'b0;
    tri_load   = 1'b0;
    case (state)
      IDLE: begin
        vin_ready = (gcnt < 2'd3);
        if ((gcnt == 2'd3) && !busy) begin
          next_state = SEND1;
        end else begin
          next_state = IDLE;
        end
      end
      SEND1: begin
        nt         = 1'b1;
        xi         = vx[0];
        yi         = vy[0];
        next_state = SEND2;
      end
      SEND2: begin
        xi         = vx[1];
        yi         = vy[1];
        next_state = SEND3;
      end
      SEND3: begin
        xi         = vx[2];
        yi         = vy[2];
        next_state = WAIT_HI;
      end
      WAIT_HI: begin
        if (busy) begin
          next_state = WAIT_LO;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_fire   = 1'b1;
          tri_done   = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!busy) begin
          tri_done   = 1'b1;
          tri_load   = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = WAIT_LO;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    vin_hs = vin_valid & vin_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Vertex gather: count handshakes and store each vertex in its slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= {COORD_W{1'b0}};
        vy[i] <= {COORD_W{1'b0}};
      end
    end else begin
      if (tri_done) begin
        gcnt <= 2'd0;
      end else if (vin_hs) begin
        gcnt <= gcnt + 2'd1;
      end
      for (int i = 0; i < 3; i++) begin
        if (vin_hs && (gcnt == 2'(i))) begin
          vx[i] <= vin_x;
          vy[i] <= vin_y;
        end
      end
    end
  end

  // Busy-rise timeout counter, restarted as the last vertex goes out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= {TMO_W{1'b0}};
    end else if (state == SEND3) begin
      tmo_cnt <= {TMO_W{1'b0}};
    end else if ((state == WAIT_HI) && !busy && !tmo_fire) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Per-triangle pixel count; reported on normal completion, cleared after any finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt    <= {PIX_CNT_W{1'b0}};
      tri_pixels <= 7'd0;
    end else begin
      if (tri_load) begin
        tri_pixels <= pix_cnt_inc(pix_cnt, po);
      end
      if (tri_done) begin
        pix_cnt <= {PIX_CNT_W{1'b0}};
      end else begin
        pix_cnt <= pix_cnt_inc(pix_cnt, po);
      end
    end
  end

  // Sticky error flags; a new error event outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      if (fifo_drop) begin
        err_ovf <= 1'b1;
      end else if (clr_err) begin
        err_ovf <= 1'b0;
      end
      if (tmo_fire) begin
        err_tmo <= 1'b1;
      end else if (clr_err) begin
        err_tmo <= 1'b0;
      end
    end
  end

  tri_pix_fifo #(
    .DW    (2 * COORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (po),
    .push_data  ({xo, yo}),
    .pop_ready  (pix_ready),
    .head_valid (pix_valid),
    .head_data  (head_data),
    .drop       (fifo_drop)
  );

  assign pix_x = head_data[2*COORD_W-1:COORD_W];
  assign pix_y = head_data[COORD_W-1:0];

endmodule

// File: tb/tb_tri_host.sv
// Directed bench for tri_host. Stimulus pushes expected vertex sends and
// expected FIFO pixels into queues; a negedge monitor pops and compares
// whenever the DUT presents a send cycle or a popped pixel.
module tb_tri_host;

  logic       clk;
  logic       reset;
  logic       vin_valid;
  logic       vin_ready;
  logic [2:0] vin_x;
  logic [2:0] vin_y;
  logic       nt;
  logic [2:0] xi;
  logic [2:0] yi;
  logic       busy;
  logic       po;
  logic [2:0] xo;
  logic [2:0] yo;
  logic       pix_valid;
  logic       pix_ready;
  logic [2:0] pix_x;
  logic [2:0] pix_y;
  logic       tri_done;
  logic [6:0] tri_pixels;
  logic       clr_err;
  logic       err_ovf;
  logic       err_tmo;

  int nvec  = 0;
  int nfail = 0;

  logic [6:0] vq [$];
  logic [5:0] pq [$];

  tri_host #(
    .COORD_W    (3),
    .FIFO_DEPTH (8),
    .TIMEOUT    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vin_valid  (vin_valid),
    .vin_ready  (vin_ready),
    .vin_x      (vin_x),
    .vin_y      (vin_y),
    .nt         (nt),
    .xi         (xi),
    .yi         (yi),
    .busy       (busy),
    .po         (po),
    .xo         (xo),
    .yo         (yo),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .tri_done   (tri_done),
    .tri_pixels (tri_pixels),
    .clr_err    (clr_err),
    .err_ovf    (err_ovf),
    .err_tmo    (err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: vertex sends and FIFO pops against the scoreboard queues.
  initial begin
    int         vphase;
    logic [6:0] ev;
    logic [5:0] ep;
    vphase = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        vphase = 0;
      end else begin
        if (nt || (vphase != 0)) begin
          if (vq.size() == 0) begin
            chk("vtx_unexpected", int'({nt, xi, yi}), -1);
          end else begin
            ev = vq.pop_front();
            chk("vtx_send", int'({nt, xi, yi}), int'(ev));
          end
          vphase = (vphase == 2) ? 0 : vphase + 1;
        end else begin
          chk("idle_xy_zero", int'({xi, yi}), 0);
        end
        if (pix_valid && pix_ready) begin
          if (pq.size() == 0) begin
            chk("pix_unexpected", int'({pix_x, pix_y}), -1);
          end else begin
            ep = pq.pop_front();
            chk("pix_order", int'({pix_x, pix_y}), int'(ep));
          end
        end
      end
    end
  end

  // Present three vertices; called and returns at #1 after a posedge.
  task automatic send_tri(input logic [5:0] v0, input logic [5:0] v1, input logic [5:0] v2);
    logic [5:0] vs [3];
    int b;
    vs[0] = v0;
    vs[1] = v1;
    vs[2] = v2;
    vq.push_back({1'b1, v0});
    vq.push_back({1'b0, v1});
    vq.push_back({1'b0, v2});
    for (int i = 0; i < 3; i++) begin
      vin_valid = 1'b1;
      {vin_x, vin_y} = vs[i];
      b = 0;
      while (!vin_ready && (b < 20)) begin
        @(posedge clk); #1;
        b++;
      end
      chk("vin_ready_hs", int'(vin_ready), 1);
      @(posedge clk); #1;
    end
    vin_valid = 1'b0;
  endtask

  // Wait for the SEND1 cycle; returns at its negedge with idle-cycle count.
  task automatic wait_nt(output int k);
    k = 0;
    @(negedge clk);
    while (!nt && (k < 50)) begin
      k++;
      @(negedge clk);
    end
    chk("nt_seen", int'(nt), 1);
  endtask

  // Behavioural engine: busy in WAIT_HI, npix pixels, busy low to finish.
  task automatic engine(input int npix, input int seed);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    busy = 1'b1;
    for (int i = 0; i < npix; i++) begin
      po = 1'b1;
      xo = 3'((i + seed) % 8);
      yo = 3'((i * 3 + seed) % 8);
      pq.push_back({xo, yo});
      @(posedge clk); #1;
    end
    po   = 1'b0;
    busy = 1'b0;
    @(negedge clk);
    chk("tri_done_pulse", int'(tri_done), 1);
    @(posedge clk); #1;
    chk("tri_done_one_cycle", int'(tri_done), 0);
    chk("tri_pixels", int'(tri_pixels), npix);
  endtask

  // Let the monitor empty the scoreboard, then confirm the FIFO is empty.
  task automatic drain();
    int b;
    b = 0;
    while ((pq.size() != 0) && (b < 40)) begin
      @(negedge clk); #1;
      b++;
    end
    chk("scoreboard_drained", pq.size(), 0);
    @(posedge clk); #1;
    chk("fifo_empty", int'(pix_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    reset     = 1'b1;
    vin_valid = 1'b0;
    vin_x     = 3'd0;
    vin_y     = 3'd0;
    busy      = 1'b0;
    po        = 1'b0;
    xo        = 3'd0;
    yo        = 3'd0;
    pix_ready = 1'b1;
    clr_err   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_vin_ready", int'(vin_ready), 1);
    chk("rst_nt", int'(nt), 0);
    chk("rst_xy", int'({xi, yi}), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_tri_done", int'(tri_done), 0);
    chk("rst_tri_pixels", int'(tri_pixels), 0);
    chk("rst_errs", int'({err_ovf, err_tmo}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Triangle (1,0),(6,5),(1,7) with 16 rendered pixels.
    send_tri({3'd1, 3'd0}, {3'd6, 3'd5}, {3'd1, 3'd7});
    wait_nt(k);
    chk("send1_latency", k, 1);
    engine(16, 0);
    drain();

    // Busy high while gathered: no nt until busy drops, then SEND1 next cycle.
    busy = 1'b1;
    send_tri({3'd2, 3'd3}, {3'd4, 3'd5}, {3'd6, 3'd7});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nt_held_busy", int'(nt), 0);
    end
    @(posedge clk); #1;
    busy = 1'b0;
    wait_nt(k);
    chk("send1_after_busy", k, 1);
    engine(3, 5);
    drain();

    // Overflow: 10 pushes with no pops keep 8, then clear, then full+pop push.
    pix_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        chk("no_ovf_at_full", int'(err_ovf), 0);
      end
      po = 1'b1;
      xo = 3'(i);
      yo = 3'(7 - i);
      if (i < 8) begin
        pq.push_back({xo, yo});
      end
      @(posedge clk); #1;
    end
    po = 1'b0;
    chk("ovf_set", int'(err_ovf), 1);
    chk("ovf_fifo_valid", int'(pix_valid), 1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("ovf_cleared", int'(err_ovf), 0);
    po        = 1'b1;
    xo        = 3'd5;
    yo        = 3'd2;
    pq.push_back({xo, yo});
    pix_ready = 1'b1;
    @(posedge clk); #1;
    po = 1'b0;
    chk("full_pop_push_ok", int'(err_ovf), 0);
    drain();

    // Timeout: busy never rises; tri_pixels keeps the last completed count.
    send_tri({3'd0, 3'd0}, {3'd7, 3'd7}, {3'd3, 3'd3});
    wait_nt(k);
    @(negedge clk);
    @(negedge clk);
    for (int w = 1; w <= 16; w++) begin
      @(negedge clk);
      if (w == 15) begin
        chk("tmo_not_early", int'(tri_done), 0);
      end else if (w == 16) begin
        chk("tmo_tri_done", int'(tri_done), 1);
        chk("tmo_flag_pre", int'(err_tmo), 0);
      end
    end
    @(negedge clk);
    chk("tmo_flag", int'(err_tmo), 1);
    chk("tmo_tri_pixels_kept", int'(tri_pixels), 3);
    chk("tmo_vin_ready", int'(vin_ready), 1);
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("tmo_cleared", int'(err_tmo), 0);
    send_tri({3'd1, 3'd2}, {3'd3, 3'd4}, {3'd5, 3'd6});
    wait_nt(k);
    engine(2, 1);
    drain();

    // Reset during SEND2 with pixels parked in the FIFO.
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      po = 1'b1;
      xo = 3'(i + 1);
      yo = 3'(i + 2);
      @(posedge clk); #1;
    end
    po = 1'b0;
    send_tri({3'd2, 3'd1}, {3'd5, 3'd6}, {3'd3, 3'd4});
    wait_nt(k);
    @(posedge clk); #1;
    chk("send2_vertex", int'({nt, xi, yi}), int'({1'b0, 3'd5, 3'd6}));
    #1;
    reset = 1'b1;
    vq.delete();
    #1;
    chk("arst_nt", int'(nt), 0);
    chk("arst_xy", int'({xi, yi}), 0);
    chk("arst_vin_ready", int'(vin_ready), 1);
    chk("arst_fifo_empty", int'(pix_valid), 0);
    chk("arst_tri_done", int'(tri_done), 0);
    @(posedge clk); #1;
    reset     = 1'b0;
    pix_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_fifo_empty", int'(pix_valid), 0);
    chk("post_rst_nt", int'(nt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/tri_host.md
TRI_HOST -- requirements
Module: tri_host

Interface
REQ-001 SHALL have parameters: COORD_W, default 3, coordinate bit width; FIFO_DEPTH, default 8, pixel FIFO entries; TIMEOUT, default 16, maximum cycles to wait for busy rise.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- vin_valid  in  1  upstream vertex valid.
- vin_ready  out  1  vertex accepted when high with vin_valid.
- vin_x, vin_y  in  COORD_W  vertex coordinates.
- nt  out  1  new-triangle strobe to engine.
- xi, yi  out  COORD_W  vertex to engine.
- busy  in  1  engine busy.
- po  in  1  engine pixel valid.
- xo, yo  in  COORD_W  engine pixel.
- pix_valid  out  1  FIFO head valid.
- pix_ready  in  1  downstream pop.
- pix_x, pix_y  out  COORD_W  FIFO head pixel.
- tri_done  out  1  one-cycle pulse, triangle finished.
- tri_pixels  out  7  pixel count of last finished triangle.
- clr_err  in  1  clears sticky errors.
- err_ovf, err_tmo  out  1  sticky overflow and timeout flags.

Function
REQ-003 SHALL implement states IDLE, SEND1, SEND2, SEND3, WAIT_HI, WAIT_LO.
REQ-004 IDLE: vin_ready=1 while the gather count is below 3; each vin_valid&vin_ready handshake stores one vertex in slot gcnt, and gcnt increments.
REQ-005 IDLE with gcnt==3 and busy==0 SHALL go to SEND1; with busy==1 it SHALL stay in IDLE.
REQ-006 SEND1: nt=1, xi/yi=vertex0; SEND2: nt=0, vertex1; SEND3: nt=0, vertex2; each state lasts exactly one cycle.
REQ-007 Outside SEND1-3: nt=0 and xi=yi=0 (no high-Z).
REQ-008 After SEND3 SHALL enter WAIT_HI and clear the timeout counter; busy==1 in WAIT_HI goes to WAIT_LO.
REQ-009 If WAIT_HI has lasted TIMEOUT cycles with busy==0, SHALL set err_tmo, pulse tri_done, and return to IDLE with gcnt=0.
REQ-010 WAIT_LO with busy==0 SHALL pulse tri_done the same cycle, load tri_pixels, return to IDLE, and set gcnt=0.
REQ-011 Each cycle with po==1 (any state) SHALL increment the per-triangle pixel counter, saturating at 127; the counter clears on the cycle after tri_done.
REQ-012 Each cycle with po==1 SHALL push {xo,yo} into the pixel FIFO.
REQ-013 If the FIFO is full and not popped, a push SHALL be dropped and err_ovf set; if full and popped the same cycle, the push SHALL be accepted.
REQ-014 pix_valid SHALL equal FIFO non-empty; a pop occurs on pix_valid&pix_ready; pix_x/pix_y show the head entry.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop when empty SHALL push only.
REQ-016 clr_err SHALL clear err_ovf and err_tmo; a set event in the same cycle SHALL win.

Reset
REQ-017 Reset SHALL give: state=IDLE, gcnt=0, FIFO empty, nt=0, xi=yi=0, vin_ready=1, pix_valid=0, tri_done=0, tri_pixels=0, err_ovf=err_tmo=0.
REQ-018 Reset during any state SHALL abort the triangle immediately and discard stored vertices and FIFO contents.

Structure
REQ-019 Package tri_pkg SHALL hold the state enum, COORD_W, FIFO_DEPTH, TIMEOUT and pixel-count width.
REQ-020 The pixel FIFO SHALL be the sub-module tri_pix_fifo; tri_host SHALL contain the FSM, vertex registers and counters.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Vertices (1,0),(6,5),(1,7) -> nt high only in the first send cycle, xi/yi = 1/0, 6/5, 1/7 on consecutive cycles.
- Behavioural engine renders 16 pixels -> 16 FIFO pops in order, tri_done pulse, tri_pixels=16.
- busy held high when 3 vertices are gathered -> no nt until busy falls; SEND1 follows on the next cycle.
- pix_ready=0 with 10 po pulses -> 8 stored, err_ovf=1; clr_err clears it.
- busy never rises -> err_tmo=1 after 16 WAIT_HI cycles, tri_done pulse, next triangle accepted.
- reset asserted in SEND2 -> nt=0 and xi=yi=0 asynchronously, FIFO empty, vin_ready=1.
